// File: rtl/fpu_cmp_issue.sv
// Initiator for the FPU compare command interface: request handshake in, compare command out, held SR.T response back.
// Optional macro FPU_CMP_ISSUE_LTLE_EN enables LT/LE via operand-swapped GT/GE.
`ifndef UMEM_OK_READY
`define UMEM_OK_READY 2'b00
`endif
`ifndef UMEM_OK_OK
`define UMEM_OK_OK 2'b01
`endif
`ifndef UMEM_OK_HOLD
`define UMEM_OK_HOLD 2'b10
`endif
`ifndef UMEM_OK_FAULT
`define UMEM_OK_FAULT 2'b11
`endif
`ifndef JX2_UCIX_FPU_CMPNE
`define JX2_UCIX_FPU_CMPNE 6'h14
`endif
`ifndef JX2_UCIX_FPU_CMPEQ
`define JX2_UCIX_FPU_CMPEQ 6'h15
`endif
`ifndef JX2_UCIX_FPU_CMPGT
`define JX2_UCIX_FPU_CMPGT 6'h16
`endif
`ifndef JX2_UCIX_FPU_CMPGE
`define JX2_UCIX_FPU_CMPGE 6'h17
`endif

module fpu_cmp_issue #(
  parameter logic [7:0] CMD_OP  = 8'h00,
  parameter int         TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [2:0]  reqCond,
  input  logic [63:0] reqValRs,
  input  logic [63:0] reqValRt,
  output logic [7:0]  cmpOpCmd,
  output logic [7:0]  cmpIdIxt,
  output logic [63:0] cmpValRs,
  output logic [63:0] cmpValRt,
  input  logic [1:0]  cmpOK,
  input  logic        cmpSrT,
  output logic        resValid,
  input  logic        resReady,
  output logic        resSrT,
  output logic        resFault,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPT, ST_RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]    op_cmd_q, op_cmd_d;
  logic [7:0]    id_ixt_q, id_ixt_d;
  logic [63:0]   val_rs_q, val_rs_d;
  logic [63:0]   val_rt_q, val_rt_d;
  logic          req_ready_q, req_ready_d;
  logic          res_valid_q, res_valid_d;
  logic          res_srt_q, res_srt_d;
  logic          res_fault_q, res_fault_d;
  logic          busy_q, busy_d;
  logic [7:0]    enc_s;

  // Returns {legal, swap_operands, ucix[5:0]} for a condition code.
  function automatic logic [7:0] enc_cond(input logic [2:0] cond);
    case (cond)
      3'd0:    enc_cond = {1'b1, 1'b0, `JX2_UCIX_FPU_CMPEQ};
      3'd1:    enc_cond = {1'b1, 1'b0, `JX2_UCIX_FPU_CMPGT};
      3'd2:    enc_cond = {1'b1, 1'b0, `JX2_UCIX_FPU_CMPNE};
      3'd3:    enc_cond = {1'b1, 1'b0, `JX2_UCIX_FPU_CMPGE};
`ifdef FPU_CMP_ISSUE_LTLE_EN
      3'd4:    enc_cond = {1'b1, 1'b1, `JX2_UCIX_FPU_CMPGT};
      3'd5:    enc_cond = {1'b1, 1'b1, `JX2_UCIX_FPU_CMPGE};
`endif
      default: enc_cond = 8'h00;
    endcase
  endfunction

  assign enc_s = enc_cond(reqCond);

  // Next-state and next-output computation.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    op_cmd_d    = op_cmd_q;
    id_ixt_d    = id_ixt_q;
    val_rs_d    = val_rs_q;
    val_rt_d    = val_rt_q;
    res_valid_d = res_valid_q;
    res_srt_d   = res_srt_q;
    res_fault_d = res_fault_q;
    case (state_q)
      ST_IDLE: begin
        if (reqValid) begin
          hold_cnt_d = '0;
          if (enc_s[7]) begin
            state_d  = ST_ISSUE;
            op_cmd_d = CMD_OP;
            id_ixt_d = {2'b00, enc_s[5:0]};
            val_rs_d = enc_s[6] ? reqValRt : reqValRs;
            val_rt_d = enc_s[6] ? reqValRs : reqValRt;
          end else begin
            state_d     = ST_RESP;
            res_valid_d = 1'b1;
            res_srt_d   = 1'b0;
            res_fault_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        case (cmpOK)
          `UMEM_OK_HOLD: begin
            if (hold_cnt_q == HOLD_LIM) begin
              state_d     = ST_RESP;
              res_valid_d = 1'b1;
              res_srt_d   = 1'b0;
              res_fault_d = 1'b1;
              op_cmd_d    = 8'h00;
              id_ixt_d    = 8'h00;
              val_rs_d    = 64'h0;
              val_rt_d    = 64'h0;
            end else if (hold_cnt_q != {CW{1'b1}}) begin
              hold_cnt_d = hold_cnt_q + CW'(1);
            end else begin
              hold_cnt_d = hold_cnt_q;
            end
          end
          `UMEM_OK_FAULT: begin
            state_d     = ST_RESP;
            res_valid_d = 1'b1;
            res_srt_d   = 1'b0;
            res_fault_d = 1'b1;
            op_cmd_d    = 8'h00;
            id_ixt_d    = 8'h00;
            val_rs_d    = 64'h0;
            val_rt_d    = 64'h0;
          end
          default: state_d = ST_CAPT;
        endcase
      end
      // Command stays on the bus here: cmpSrT reflects the previous cycle's inputs.
      ST_CAPT: begin
        state_d     = ST_RESP;
        res_valid_d = 1'b1;
        res_srt_d   = cmpSrT;
        res_fault_d = 1'b0;
        op_cmd_d    = 8'h00;
        id_ixt_d    = 8'h00;
        val_rs_d    = 64'h0;
        val_rt_d    = 64'h0;
      end
      ST_RESP: begin
        if (resReady) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
          res_srt_d   = 1'b0;
          res_fault_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        hold_cnt_d  = '0;
        op_cmd_d    = 8'h00;
        id_ixt_d    = 8'h00;
        val_rs_d    = 64'h0;
        val_rt_d    = 64'h0;
        res_valid_d = 1'b0;
        res_srt_d   = 1'b0;
        res_fault_d = 1'b0;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      op_cmd_q    <= 8'h00;
      id_ixt_q    <= 8'h00;
      val_rs_q    <= 64'h0;
      val_rt_q    <= 64'h0;
      req_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_srt_q   <= 1'b0;
      res_fault_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      op_cmd_q    <= op_cmd_d;
      id_ixt_q    <= id_ixt_d;
      val_rs_q    <= val_rs_d;
      val_rt_q    <= val_rt_d;
      req_ready_q <= req_ready_d;
      res_valid_q <= res_valid_d;
      res_srt_q   <= res_srt_d;
      res_fault_q <= res_fault_d;
      busy_q      <= busy_d;
    end
  end

  assign reqReady = req_ready_q;
  assign cmpOpCmd = op_cmd_q;
  assign cmpIdIxt = id_ixt_q;
  assign cmpValRs = val_rs_q;
  assign cmpValRt = val_rt_q;
  assign resValid = res_valid_q;
  assign resSrT   = res_srt_q;
  assign resFault = res_fault_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_fpu_cmp_issue.sv
// Directed, table-driven bench for fpu_cmp_issue with a registered compare-unit model.
module tb_fpu_cmp_issue;

  localparam logic [1:0] OK_READY = 2'b00;
  localparam logic [1:0] OK_OK    = 2'b01;
  localparam logic [1:0] OK_HOLD  = 2'b10;
  localparam logic [1:0] OK_FAULT = 2'b11;
  localparam logic [7:0] IX_NE = 8'h14;
  localparam logic [7:0] IX_EQ = 8'h15;
  localparam logic [7:0] IX_GT = 8'h16;
  localparam logic [7:0] IX_GE = 8'h17;
  localparam logic [63:0] D1 = 64'h3FF0000000000000;
  localparam logic [63:0] D2 = 64'h4000000000000000;

  logic        clock, reset;
  logic        reqValid, reqReady;
  logic [2:0]  reqCond;
  logic [63:0] reqValRs, reqValRt;
  logic [7:0]  cmpOpCmd, cmpIdIxt;
  logic [63:0] cmpValRs, cmpValRt;
  logic [1:0]  cmpOK;
  logic        cmpSrT;
  logic        resValid, resReady, resSrT, resFault, busy;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_cmp_issue #(.CMD_OP(8'h00), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqCond(reqCond),
    .reqValRs(reqValRs), .reqValRt(reqValRt),
    .cmpOpCmd(cmpOpCmd), .cmpIdIxt(cmpIdIxt), .cmpValRs(cmpValRs), .cmpValRt(cmpValRt),
    .cmpOK(cmpOK), .cmpSrT(cmpSrT),
    .resValid(resValid), .resReady(resReady), .resSrT(resSrT), .resFault(resFault),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare unit model: result registered one cycle after the command (positive operands only).
  always @(posedge clock) begin
    case (cmpIdIxt)
      IX_EQ:   cmpSrT <= (cmpValRs == cmpValRt);
      IX_NE:   cmpSrT <= (cmpValRs != cmpValRt);
      IX_GT:   cmpSrT <= (cmpValRs >  cmpValRt);
      IX_GE:   cmpSrT <= (cmpValRs >= cmpValRt);
      default: cmpSrT <= 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts at a negedge; returns at the negedge where resValid is first seen.
  task automatic run_req(input logic [2:0] cond, input logic [63:0] rs, input logic [63:0] rt,
                         input int n_hold, input logic [1:0] final_ok,
                         output int lat, output logic srt, output logic fault,
                         output logic [7:0] idixt, output logic [63:0] vrs, output logic [63:0] vrt);
    int  hold;
    bit  done;
    reqValid = 1'b1; reqCond = cond; reqValRs = rs; reqValRt = rt; cmpOK = OK_READY;
    chk("req_ready_before_accept", {63'h0, reqReady}, 64'h1);
    @(posedge clock);
    lat = 1; hold = n_hold; done = 1'b0;
    idixt = 8'h00; vrs = 64'h0; vrt = 64'h0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clock);
      reqValid = 1'b0;
      if (resValid) begin
        done = 1'b1;
      end else begin
        if (cmpIdIxt != 8'h00 && idixt == 8'h00) begin
          idixt = cmpIdIxt; vrs = cmpValRs; vrt = cmpValRt;
        end
        if (hold > 0) begin
          cmpOK = OK_HOLD; hold--;
        end else begin
          cmpOK = final_ok;
        end
        @(posedge clock);
        lat++;
      end
    end
    if (!done) chk("resp_wait_timeout", 64'h0, 64'h1);
    srt = resSrT; fault = resFault; cmpOK = OK_READY;
  endtask

  // Accepts the pending response; starts and ends at a negedge.
  task automatic finish_resp();
    resReady = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resReady = 1'b0;
    chk("resvalid_cleared", {63'h0, resValid}, 64'h0);
    chk("reqready_after_resp", {63'h0, reqReady}, 64'h1);
  endtask

  typedef struct {
    logic [2:0]  cond;
    logic [63:0] rs, rt;
    logic [7:0]  idixt;
    logic [63:0] vrs, vrt;
    logic        srt, fault;
    int          lat;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int          lat;
    logic        srt, fault, held_srt;
    logic [7:0]  idixt;
    logic [63:0] vrs, vrt;

    vecs[0] = '{3'd0, D1, D1, IX_EQ, D1, D1, 1'b1, 1'b0, 3};
    vecs[1] = '{3'd1, D2, D1, IX_GT, D2, D1, 1'b1, 1'b0, 3};
    vecs[2] = '{3'd2, D2, D1, IX_NE, D2, D1, 1'b1, 1'b0, 3};
    vecs[3] = '{3'd3, D1, D1, IX_GE, D1, D1, 1'b1, 1'b0, 3};
    vecs[4] = '{3'd0, D2, D1, IX_EQ, D2, D1, 1'b0, 1'b0, 3};
    vecs[5] = '{3'd1, D1, D2, IX_GT, D1, D2, 1'b0, 1'b0, 3};
`ifdef FPU_CMP_ISSUE_LTLE_EN
    vecs[6] = '{3'd4, D1, D2, IX_GT, D2, D1, 1'b1, 1'b0, 3};
    vecs[7] = '{3'd5, D2, D1, IX_GE, D1, D2, 1'b0, 1'b0, 3};
`else
    vecs[6] = '{3'd4, D1, D2, 8'h00, 64'h0, 64'h0, 1'b0, 1'b1, 1};
    vecs[7] = '{3'd5, D2, D1, 8'h00, 64'h0, 64'h0, 1'b0, 1'b1, 1};
`endif
    vecs[8] = '{3'd6, D1, D1, 8'h00, 64'h0, 64'h0, 1'b0, 1'b1, 1};
    vecs[9] = '{3'd7, D2, D1, 8'h00, 64'h0, 64'h0, 1'b0, 1'b1, 1};

    reset = 1'b0; reqValid = 1'b0; reqCond = 3'd0; reqValRs = 64'h0; reqValRt = 64'h0;
    cmpOK = OK_READY; resReady = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_reqready", {63'h0, reqReady}, 64'h1);
    chk("rst_resvalid", {63'h0, resValid}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_cmd", {cmpOpCmd, cmpIdIxt}, 64'h0);
    chk("rst_ops", cmpValRs | cmpValRt, 64'h0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].cond, vecs[i].rs, vecs[i].rt, 0, OK_READY, lat, srt, fault, idixt, vrs, vrt);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_srt", i), {63'h0, srt}, {63'h0, vecs[i].srt});
      chk($sformatf("v%0d_fault", i), {63'h0, fault}, {63'h0, vecs[i].fault});
      chk($sformatf("v%0d_idixt", i), {56'h0, idixt}, {56'h0, vecs[i].idixt});
      chk($sformatf("v%0d_valrs", i), vrs, vecs[i].vrs);
      chk($sformatf("v%0d_valrt", i), vrt, vecs[i].vrt);
      chk($sformatf("v%0d_busy", i), {63'h0, busy}, 64'h1);
      finish_resp();
    end

    // Five HOLD cycles then READY.
    run_req(3'd1, D2, D1, 5, OK_READY, lat, srt, fault, idixt, vrs, vrt);
    chk("hold5_lat", 64'(lat), 64'd8);
    chk("hold5_srt", {63'h0, srt}, 64'h1);
    chk("hold5_fault", {63'h0, fault}, 64'h0);
    finish_resp();

    // Permanent HOLD: timeout after 16 ISSUE cycles.
    run_req(3'd0, D1, D1, 1000, OK_HOLD, lat, srt, fault, idixt, vrs, vrt);
    chk("timeout_lat", 64'(lat), 64'd17);
    chk("timeout_fault", {63'h0, fault}, 64'h1);
    chk("timeout_srt", {63'h0, srt}, 64'h0);
    finish_resp();

    // FAULT status from the compare unit.
    run_req(3'd0, D1, D1, 0, OK_FAULT, lat, srt, fault, idixt, vrs, vrt);
    chk("okfault_lat", 64'(lat), 64'd2);
    chk("okfault_fault", {63'h0, fault}, 64'h1);
    chk("okfault_srt", {63'h0, srt}, 64'h0);
    finish_resp();

    // Unlisted status code behaves as READY.
    run_req(3'd0, D1, D1, 0, OK_OK, lat, srt, fault, idixt, vrs, vrt);
    chk("okok_lat", 64'(lat), 64'd3);
    chk("okok_srt", {63'h0, srt}, 64'h1);
    finish_resp();

    // Response backpressure with a competing request.
    run_req(3'd2, D2, D1, 0, OK_READY, lat, srt, fault, idixt, vrs, vrt);
    held_srt = srt;
    chk("bp_srt", {63'h0, srt}, 64'h1);
    reqValid = 1'b1; reqCond = 3'd0; reqValRs = D1; reqValRt = D1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("bp%0d_resvalid", i), {63'h0, resValid}, 64'h1);
      chk($sformatf("bp%0d_srt", i), {63'h0, resSrT}, {63'h0, held_srt});
      chk($sformatf("bp%0d_reqready", i), {63'h0, reqReady}, 64'h0);
    end
    resReady = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resReady = 1'b0;
    chk("bp_release_resvalid", {63'h0, resValid}, 64'h0);
    chk("bp_release_not_accepted", {63'h0, busy}, 64'h0);
    run_req(3'd0, D1, D1, 0, OK_READY, lat, srt, fault, idixt, vrs, vrt);
    chk("bp_next_lat", 64'(lat), 64'd3);
    chk("bp_next_srt", {63'h0, srt}, 64'h1);
    finish_resp();

    // Reset asserted during CAPT.
    reqValid = 1'b1; reqCond = 3'd0; reqValRs = D1; reqValRt = D1; cmpOK = OK_READY;
    @(posedge clock);
    @(negedge clock);
    reqValid = 1'b0;
    chk("pre_rst_idixt", {56'h0, cmpIdIxt}, {56'h0, IX_EQ});
    @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midrst_reqready", {63'h0, reqReady}, 64'h1);
    chk("midrst_cmd", {cmpOpCmd, cmpIdIxt}, 64'h0);
    chk("midrst_ops", cmpValRs | cmpValRt, 64'h0);
    chk("midrst_resp", {62'h0, resValid, resFault}, 64'h0);
    chk("midrst_busy", {63'h0, busy}, 64'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_resvalid", {63'h0, resValid}, 64'h0);
    run_req(3'd0, D1, D1, 0, OK_READY, lat, srt, fault, idixt, vrs, vrt);
    chk("post_rst_lat", 64'(lat), 64'd3);
    chk("post_rst_srt", {63'h0, srt}, 64'h1);
    chk("post_rst_fault", {63'h0, fault}, 64'h0);
    finish_resp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
